// File: rtl/voice_allocator_if.sv
// Event and note-bank signals of the voice allocator.
// master: event source / bank side. slave: the allocator itself.
interface voice_allocator_if #(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS_IN  = 18
);
    logic                          ev_valid;
    logic                          ev_ready;
    logic                          ev_note_on;
    logic [6:0]                    ev_key;
    logic [6:0]                    ev_velocity;
    logic [NUM_BITS_IN-1:0]        ev_word;
    logic                          all_off;
    logic [NUM_CHANNELS-1:0]       available;
    logic [NUM_CHANNELS-1:0]       reg_en;
    logic [NUM_CHANNELS-1:0]       note_en;
    logic [NUM_BITS_IN-1:0]        note_in;
    logic [32*NUM_CHANNELS-1:0]    velocity_out;
    logic                          steal;

    modport master (
        output ev_valid, ev_note_on, ev_key, ev_velocity, ev_word, all_off, available,
        input  ev_ready, reg_en, note_en, note_in, velocity_out, steal
    );

    modport slave (
        input  ev_valid, ev_note_on, ev_key, ev_velocity, ev_word, all_off, available,
        output ev_ready, reg_en, note_en, note_in, velocity_out, steal
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans every channel once per event, then picks
// key match, else first free channel, else the oldest channel (steal).
//
// state  | meaning
// IDLE   | ready for an event
// SCAN   | examine channel idx, one per cycle
// COMMIT | load / gate the chosen channel
// RETRIG | raise the gate again after a one-cycle low (match or steal)
module voice_allocator #(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS_IN  = 18,
    parameter int AGE_BITS     = 8
) (
    input  logic              clk,
    input  logic              rst,
    voice_allocator_if.slave  bus
);
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RETRIG} state_t;

    state_t                     state;
    state_t                     state_nxt;

    logic [IDX_W-1:0]           idx;
    logic                       lat_note_on;
    logic [6:0]                 lat_key;
    logic [6:0]                 lat_vel;
    logic [NUM_BITS_IN-1:0]     lat_word;

    logic                       match_found;
    logic [IDX_W-1:0]           match_idx;
    logic                       free_found;
    logic [IDX_W-1:0]           free_idx;
    logic [IDX_W-1:0]           old_idx;
    logic [AGE_BITS-1:0]        old_age;

    logic [6:0]                 keys [NUM_CHANNELS];
    logic [AGE_BITS-1:0]        ages [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]    reg_en_q;
    logic [NUM_CHANNELS-1:0]    note_en_q;
    logic [NUM_BITS_IN-1:0]     note_in_q;
    logic [32*NUM_CHANNELS-1:0] velocity_q;
    logic                       steal_q;

    logic                       accept;
    logic [IDX_W-1:0]           commit_target;
    logic                       retrig_path;

    assign bus.ev_ready     = (state == IDLE) && !rst;
    assign accept           = bus.ev_valid && bus.ev_ready;
    assign bus.reg_en       = reg_en_q;
    assign bus.note_en      = note_en_q;
    assign bus.note_in      = note_in_q;
    assign bus.velocity_out = velocity_q;
    assign bus.steal        = steal_q;

    // Target selection from the finished scan; stays stable through RETRIG.
    always_comb begin
        commit_target = old_idx;
        if (free_found)
            commit_target = free_idx;
        if (match_found)
            commit_target = match_idx;
        retrig_path = match_found || !free_found;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; panic release overrides everything.
    always_comb begin
        state_nxt = state;
        if (bus.all_off) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = SCAN;
                SCAN:    if (idx == LAST_IDX) state_nxt = COMMIT;
                COMMIT:  state_nxt = (lat_note_on && retrig_path) ? RETRIG : IDLE;
                RETRIG:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Event latch, channel scan, bank outputs and per-channel key/age store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            lat_note_on <= 1'b0;
            lat_key     <= '0;
            lat_vel     <= '0;
            lat_word    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            reg_en_q    <= '0;
            note_en_q   <= '0;
            note_in_q   <= '0;
            velocity_q  <= '0;
            steal_q     <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                keys[i] <= '0;
                ages[i] <= '0;
            end
        end else begin
            reg_en_q <= '0;
            steal_q  <= 1'b0;
            if (bus.all_off) begin
                note_en_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            lat_note_on <= bus.ev_note_on;
                            lat_key     <= bus.ev_key;
                            lat_vel     <= bus.ev_velocity;
                            lat_word    <= bus.ev_word;
                            idx         <= '0;
                            match_found <= 1'b0;
                            free_found  <= 1'b0;
                            old_idx     <= '0;
                            old_age     <= '0;
                        end
                    end
                    SCAN: begin
                        if (!match_found && note_en_q[idx] && keys[idx] == lat_key) begin
                            match_found <= 1'b1;
                            match_idx   <= idx;
                        end
                        if (!free_found && bus.available[idx] && !note_en_q[idx]) begin
                            free_found <= 1'b1;
                            free_idx   <= idx;
                        end
                        // Strict compare keeps the lowest index on ties.
                        if (idx == '0 || ages[idx] > old_age) begin
                            old_idx <= idx;
                            old_age <= ages[idx];
                        end
                        idx <= idx + IDX_W'(1);
                    end
                    COMMIT: begin
                        if (lat_note_on) begin
                            reg_en_q[commit_target]  <= 1'b1;
                            note_in_q                <= lat_word;
                            keys[commit_target]      <= lat_key;
                            velocity_q[32*commit_target +: 32] <= {lat_vel, 25'b0};
                            note_en_q[commit_target] <= !retrig_path;
                            steal_q                  <= !match_found && !free_found;
                            for (int i = 0; i < NUM_CHANNELS; i++) begin
                                if (IDX_W'(i) == commit_target)
                                    ages[i] <= '0;
                                else if (ages[i] != {AGE_BITS{1'b1}})
                                    ages[i] <= ages[i] + AGE_BITS'(1);
                            end
                        end else if (match_found) begin
                            note_en_q[match_idx] <= 1'b0;
                        end
                    end
                    RETRIG: begin
                        note_en_q[commit_target] <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
